// File: rtl/s_machine_control_unit.sv
// S-Machine fetch/decode/execute sequencer.
// Owns PC/IR and arbitrates one memory port between fetch and LD/ST.
module s_machine_control_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] PC_RESET = 8'h00
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               mem_ready,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] ir,
  output logic [3:0]         alu_op,
  output logic [1:0]         rd,
  output logic [1:0]         rs,
  output logic [7:0]         imm,
  output logic               reg_we,
  output logic               flag_we,
  output logic               retire,
  output logic               busy
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_pc;
  logic [INSTR_W-1:0]  r_ir;
  logic                w_ir_ld;
  logic                w_pc_inc;
  logic                w_pc_br;
  logic [3:0]          w_op;
  logic                w_is_st;
  logic                w_is_mem;
  logic                w_is_cmp;
  logic                w_is_br;

  assign w_op     = r_ir[15:12];
  assign w_is_st  = (w_op == 4'h7);
  assign w_is_mem = (w_op == 4'h7) || (w_op == 4'h8);
  assign w_is_cmp = (w_op == 4'hB);
  assign w_is_br  = (w_op == 4'hF);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_pc    <= PC_RESET;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (w_ir_ld) r_ir <= mem_rdata;
      if (w_pc_inc) r_pc <= r_pc + 1'b1;
      else if (w_pc_br) r_pc <= ADDR_W'(r_ir[7:0]);
    end
  end

  always_comb begin
    w_next   = r_state;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    reg_we   = 1'b0;
    flag_we  = 1'b0;
    retire   = 1'b0;
    w_ir_ld  = 1'b0;
    w_pc_inc = 1'b0;
    w_pc_br  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (enable) w_next = FETCH;
      end
      FETCH: begin
        mem_req  = 1'b1;
        mem_addr = r_pc;
        if (mem_ready) begin
          w_ir_ld  = 1'b1;
          w_pc_inc = 1'b1;
          w_next   = DECODE;
        end
      end
      DECODE: begin
        w_next = EXEC;
      end
      EXEC: begin
        unique case (1'b1)
          w_is_mem: w_next = MEM;
          w_is_cmp: begin
            flag_we = 1'b1;
            retire  = 1'b1;
          end
          w_is_br: begin
            w_pc_br = 1'b1;
            retire  = 1'b1;
          end
          default: begin
            reg_we = 1'b1;
            retire = 1'b1;
          end
        endcase
        if (retire) w_next = enable ? FETCH : IDLE;
      end
      MEM: begin
        mem_req  = 1'b1;
        mem_we   = w_is_st;
        mem_addr = ADDR_W'(r_ir[7:0]);
        // LD writes back the returned word in the ready cycle
        if (mem_ready) begin
          reg_we = !w_is_st;
          retire = 1'b1;
          w_next = enable ? FETCH : IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign pc     = r_pc;
  assign ir     = r_ir;
  assign alu_op = r_ir[15:12];
  assign rd     = r_ir[11:10];
  assign rs     = r_ir[9:8];
  assign imm    = r_ir[7:0];
  assign busy   = (r_state != IDLE);

endmodule

// File: tb/tb_s_machine_control_unit.sv
// Bench for s_machine_control_unit: memory responder, instruction-level
// reference model, directed vector table and randomized run.
module tb_s_machine_control_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        mem_req, mem_we;
  logic [7:0]  mem_addr, pc, imm;
  logic [15:0] ir;
  logic [3:0]  alu_op;
  logic [1:0]  rd, rs;
  logic        reg_we, flag_we, retire, busy;

  always #5 clk = ~clk;

  s_machine_control_unit dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .pc(pc), .ir(ir), .alu_op(alu_op), .rd(rd), .rs(rs),
    .imm(imm), .reg_we(reg_we), .flag_we(flag_we),
    .retire(retire), .busy(busy)
  );

  logic [15:0] mem [256];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // memory responder: per-request wait counts from wq, else random or 0
  int wq[$];
  bit rnd_wait = 0;
  bit noise = 0;
  bit in_req = 0;
  int wcnt = 0;
  int wtgt = 0;

  always @(negedge clk) begin
    if (mem_req) begin
      if (!in_req) begin
        in_req = 1;
        wcnt = 0;
        if (wq.size() > 0) wtgt = wq.pop_front();
        else wtgt = rnd_wait ? int'($urandom_range(0, 3)) : 0;
      end
      if (wcnt >= wtgt) begin
        mem_ready = 1'b1;
        mem_rdata = mem[mem_addr];
        in_req = 0;
      end else begin
        mem_ready = 1'b0;
        wcnt++;
      end
    end else begin
      in_req = 0;
      mem_ready = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
      mem_rdata = 16'($urandom);
    end
  end

  // instruction-level reference model
  bit          m_pend = 0, f_on = 0, prev_wait = 0;
  bit          busy_chk = 0, exp_busy = 0, prev_we = 0;
  bit          was_pend, isldst;
  logic [7:0]  m_pc = 8'h00, prev_addr = 8'h00;
  logic [15:0] m_ir = '0;
  logic [3:0]  op;
  int          m_cnt = 0, f_cyc = 0, n_ret = 0, cyc = 0;
  int          l_tot = 0;
  bit          l_rwe, l_fwe, l_macc, l_mwe;
  logic [7:0]  l_maddr;

  always @(negedge clk) begin
    #1;
    cyc++;
    if (!reset_n) begin
      m_pend = 0; f_on = 0; prev_wait = 0; busy_chk = 0;
      m_pc = 8'h00;
    end else begin
      was_pend = m_pend;
      op = m_ir[15:12];
      isldst = (op == 4'h7) || (op == 4'h8);
      if (busy_chk) begin
        chk("busy_next", {busy, mem_req}, {exp_busy, exp_busy});
        busy_chk = 0;
      end
      if (prev_wait)
        chk("req_hold", {mem_req, mem_we, mem_addr},
            {1'b1, prev_we, prev_addr});
      if (!busy)
        chk("idle_quiet", {mem_req, reg_we, flag_we, retire}, 4'b0);
      if (was_pend && mem_req) chk("mem_op", isldst, 1);
      if (!was_pend && mem_req && !f_on) begin
        f_on = 1;
        f_cyc = cyc;
      end
      if (was_pend && !(mem_req && !mem_ready)) m_cnt++;
      if (mem_req && mem_ready) begin
        if (!was_pend) begin
          chk("fetch_addr", {mem_we, mem_addr, pc}, {1'b0, m_pc, m_pc});
          chk("fetch_quiet", {reg_we, flag_we, retire}, 3'b0);
          m_ir = mem[m_pc];
          m_pc = m_pc + 8'd1;
          m_pend = 1; m_cnt = 1;
          l_macc = 0; l_mwe = 0; l_maddr = 8'h00;
        end else begin
          chk("data_acc", {mem_we, mem_addr}, {op == 4'h7, m_ir[7:0]});
          l_macc = 1; l_mwe = mem_we; l_maddr = mem_addr;
        end
      end
      if (retire) begin
        chk("retire_pend", was_pend, 1);
        chk("fields", {alu_op, rd, rs, imm}, m_ir);
        chk("strobes", {reg_we, flag_we},
            {op != 4'h7 && op != 4'hB && op != 4'hF, op == 4'hB});
        chk("latency", m_cnt, isldst ? 4 : 3);
        l_tot = cyc - f_cyc + 1;
        l_rwe = reg_we; l_fwe = flag_we;
        if (op == 4'hF) m_pc = m_ir[7:0];
        m_pend = 0; f_on = 0;
        n_ret++;
        busy_chk = 1;
        exp_busy = enable;
      end else if (reg_we || flag_we) begin
        chk("stray_strobe", {reg_we, flag_we}, 2'b0);
      end
      prev_wait = mem_req && !mem_ready;
      prev_addr = mem_addr;
      prev_we = mem_we;
    end
  end

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] word;
    int          wf, wm, tot;
    bit          rwe, fwe, macc, mwe;
    logic [7:0]  maddr, npc;
  } vec_t;

  vec_t tv [9];

  task automatic wait_ret(input string nm);
    int s;
    bit ok;
    s = n_ret;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #2;
      if (n_ret != s) begin
        ok = 1;
        break;
      end
    end
    chk(nm, ok, 1);
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #2;
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    chk(nm, ok, 1);
  endtask

  task automatic rst_pulse();
    @(posedge clk); #2;
    reset_n = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b1;
  endtask

  initial begin
    bit ok;
    tv[0] = '{8'h00, 16'h0002, 0, 0, 3, 1, 0, 0, 0, 8'h00, 8'h01};
    tv[1] = '{8'h01, 16'h7055, 0, 0, 4, 0, 0, 1, 1, 8'h55, 8'h02};
    tv[2] = '{8'h02, 16'h8055, 0, 3, 7, 1, 0, 1, 0, 8'h55, 8'h03};
    tv[3] = '{8'h03, 16'h1600, 2, 0, 5, 1, 0, 0, 0, 8'h00, 8'h04};
    tv[4] = '{8'h04, 16'hB100, 0, 0, 3, 0, 1, 0, 0, 8'h00, 8'h05};
    tv[5] = '{8'h05, 16'hF0F0, 0, 0, 3, 0, 0, 0, 0, 8'h00, 8'hF0};
    tv[6] = '{8'hF0, 16'h3400, 1, 0, 4, 1, 0, 0, 0, 8'h00, 8'hF1};
    tv[7] = '{8'hF1, 16'hF0FF, 0, 0, 3, 0, 0, 0, 0, 8'h00, 8'hFF};
    tv[8] = '{8'hFF, 16'hC900, 0, 0, 3, 1, 0, 0, 0, 8'h00, 8'h00};
    for (int i = 0; i < 256; i++) mem[i] = 16'h0002;
    foreach (tv[i]) mem[tv[i].addr] = tv[i].word;

    // reset values while held
    #7;
    chk("rst_hold",
        {mem_req, mem_we, mem_addr, pc, ir, reg_we, flag_we, retire, busy},
        '0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    #2;
    chk("t0_idle", {mem_req, busy, pc}, '0);

    // directed vectors, zero/fixed memory waits
    foreach (tv[i]) begin
      wq.push_back(tv[i].wf);
      if (tv[i].macc) wq.push_back(tv[i].wm);
    end
    @(posedge clk); #2;
    enable = 1'b1;
    foreach (tv[i]) begin
      wait_ret("vec_retire");
      chk("vec_tot", l_tot, tv[i].tot);
      chk("vec_acc", {l_rwe, l_fwe, l_macc, l_mwe, l_maddr},
          {tv[i].rwe, tv[i].fwe, tv[i].macc, tv[i].mwe, tv[i].maddr});
      @(negedge clk); #2;
      chk("vec_npc", pc, tv[i].npc);
    end

    // reset during a stalled LD access
    @(posedge clk); #2;
    enable = 1'b0;
    wait_idle("t5_idle");
    mem[0] = 16'h8055;
    wq.delete();
    wq.push_back(0);
    wq.push_back(10);
    rst_pulse();
    @(posedge clk); #2;
    enable = 1'b1;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #2;
      if (mem_req && mem_addr == 8'h55) begin
        ok = 1;
        break;
      end
    end
    chk("t5_in_mem", ok, 1);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("t5_async",
        {mem_req, mem_we, mem_addr, pc, ir, reg_we, flag_we, retire, busy},
        '0);
    mem[0] = 16'h0002;
    wq.delete();
    @(posedge clk); #2;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    chk("t5_refetch", {busy, mem_req, mem_we, mem_addr}, {3'b110, 8'h00});

    // enable dropped in DECODE still retires, then idles
    @(posedge clk); #2;
    enable = 1'b0;
    wait_idle("t6_pre_idle");
    rst_pulse();
    @(posedge clk); #2;
    enable = 1'b1;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #2;
      if (mem_req && mem_ready) begin
        ok = 1;
        break;
      end
    end
    chk("t6_fetched", ok, 1);
    @(posedge clk); #2;
    enable = 1'b0;
    wait_ret("t6_retire");
    chk("t6_regwe", l_rwe, 1);
    @(negedge clk); #2;
    chk("t6_busy", {busy, mem_req}, 2'b00);
    repeat (5) @(negedge clk);
    #2;
    chk("t6_stay", {busy, pc}, {1'b0, 8'h01});

    // randomized program, waits, enable and stray ready
    rst_pulse();
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    rnd_wait = 1;
    noise = 1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      enable = ($urandom_range(0, 9) != 0);
    end
    enable = 1'b0;
    wait_idle("rand_idle");
    chk("rand_retired", n_ret > 100, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
